// File: rtl/fetch_bundle_queue_if.sv
// Fetch/decode side signals of the fetch bundle queue, grouped so the queue and its
// neighbours share one definition. slave = queue view, master = fetch/decode view.
interface fetch_bundle_queue_if #(
    parameter int addressWidth            = 64,
    parameter int instructionWidth        = 32,
    parameter int bundleSize              = 128,
    parameter int PidSize                 = 20,
    parameter int TidSize                 = 16,
    parameter int instructionCounterWidth = 64
);
    logic                               flush_i;
    logic                               bundleValid_i;
    logic [bundleSize-1:0]              bundle_i;
    logic [addressWidth-1:0]            bundleAddress_i;
    logic [1:0]                         bundleLen_i;
    logic [PidSize-1:0]                 bundlePid_i;
    logic [TidSize-1:0]                 bundleTid_i;
    logic [instructionCounterWidth-1:0] bundleStartMajId_i;
    logic                               fetchStall_o;
    logic                               instValid_o;
    logic                               decodeReady_i;
    logic [instructionWidth-1:0]        inst_o;
    logic [addressWidth-1:0]            instAddress_o;
    logic [PidSize-1:0]                 instPid_o;
    logic [TidSize-1:0]                 instTid_o;
    logic [instructionCounterWidth-1:0] instMajId_o;
    logic                               overflow_o;

    modport slave (
        input  flush_i, bundleValid_i, bundle_i, bundleAddress_i, bundleLen_i,
               bundlePid_i, bundleTid_i, bundleStartMajId_i, decodeReady_i,
        output fetchStall_o, instValid_o, inst_o, instAddress_o, instPid_o,
               instTid_o, instMajId_o, overflow_o
    );

    modport master (
        output flush_i, bundleValid_i, bundle_i, bundleAddress_i, bundleLen_i,
               bundlePid_i, bundleTid_i, bundleStartMajId_i, decodeReady_i,
        input  fetchStall_o, instValid_o, inst_o, instAddress_o, instPid_o,
               instTid_o, instMajId_o, overflow_o
    );
endinterface

// File: rtl/fetch_bundle_queue.sv
// Bundle queue between fetch and decode: buffers whole bundles and hands decode one
// instruction per transfer, raising a stall to fetch one entry before the queue fills.
module fetch_bundle_queue #(
    parameter int addressWidth            = 64,
    parameter int instructionWidth        = 32,
    parameter int bundleSize              = 128,
    parameter int PidSize                 = 20,
    parameter int TidSize                 = 16,
    parameter int instructionCounterWidth = 64,
    parameter int queueDepth              = 4
) (
    input logic                 clock_i,
    input logic                 reset_i,
    fetch_bundle_queue_if.slave bus
);
    localparam int ptrWidth = $clog2(queueDepth);
    localparam int cntWidth = ptrWidth + 1;

    logic [bundleSize-1:0]              r_bundleMem [queueDepth];
    logic [addressWidth-1:0]            r_addrMem   [queueDepth];
    logic [1:0]                         r_lenMem    [queueDepth];
    logic [PidSize-1:0]                 r_pidMem    [queueDepth];
    logic [TidSize-1:0]                 r_tidMem    [queueDepth];
    logic [instructionCounterWidth-1:0] r_majMem    [queueDepth];

    logic [ptrWidth-1:0] r_wrPtr;
    logic [ptrWidth-1:0] r_rdPtr;
    logic [cntWidth-1:0] r_count;
    logic [1:0]          r_slot;
    logic                r_overflow;

    logic w_valid;
    logic w_full;
    logic w_transfer;
    logic w_pop;
    logic w_push;
    logic w_drop;

    assign w_valid    = (r_count != '0);
    assign w_full     = (r_count == cntWidth'(queueDepth));
    assign w_transfer = w_valid && bus.decodeReady_i;
    assign w_pop      = w_transfer && (r_slot == r_lenMem[r_rdPtr]);
    // A pop in the same cycle frees the head entry, so a full queue can still accept.
    assign w_push     = bus.bundleValid_i && (!w_full || w_pop);
    assign w_drop     = bus.bundleValid_i && w_full && !w_pop;

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_slot     <= '0;
            r_overflow <= 1'b0;
        end else if (bus.flush_i) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_slot     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + ptrWidth'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + ptrWidth'(1);
                r_slot  <= '0;
            end else if (w_transfer) begin
                r_slot <= r_slot + 2'd1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + cntWidth'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - cntWidth'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Entry payload needs no reset: outputs are gated by the count until written.
    always_ff @(posedge clock_i) begin
        if (w_push && !bus.flush_i) begin
            r_bundleMem[r_wrPtr] <= bus.bundle_i;
            r_addrMem[r_wrPtr]   <= bus.bundleAddress_i;
            r_lenMem[r_wrPtr]    <= bus.bundleLen_i;
            r_pidMem[r_wrPtr]    <= bus.bundlePid_i;
            r_tidMem[r_wrPtr]    <= bus.bundleTid_i;
            r_majMem[r_wrPtr]    <= bus.bundleStartMajId_i;
        end
    end

    always_comb begin
        bus.inst_o        = '0;
        bus.instAddress_o = '0;
        bus.instPid_o     = '0;
        bus.instTid_o     = '0;
        bus.instMajId_o   = '0;
        if (w_valid) begin
            bus.inst_o        = r_bundleMem[r_rdPtr][int'(r_slot) * instructionWidth +: instructionWidth];
            bus.instAddress_o = r_addrMem[r_rdPtr] + addressWidth'({r_slot, 2'b00});
            bus.instPid_o     = r_pidMem[r_rdPtr];
            bus.instTid_o     = r_tidMem[r_rdPtr];
            bus.instMajId_o   = r_majMem[r_rdPtr] + instructionCounterWidth'(r_slot);
        end
    end

    assign bus.instValid_o  = w_valid;
    assign bus.fetchStall_o = (r_count >= cntWidth'(queueDepth - 1));
    assign bus.overflow_o   = r_overflow;
endmodule

// File: tb/tb_fetch_bundle_queue.sv
// Directed bench for fetch_bundle_queue: hand-computed expectations checked with
// immediate assertions after each clock step.
module tb_fetch_bundle_queue;
    logic clock_i;
    logic reset_i;
    int   testsRun;
    int   testsFailed;

    fetch_bundle_queue_if bus ();

    fetch_bundle_queue dut (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .bus     (bus)
    );

    initial clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    function automatic logic [127:0] makeBundle(input logic [31:0] base);
        return {base + 32'd3, base + 32'd2, base + 32'd1, base};
    endfunction

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] base,
                                 input logic [63:0] addr, input logic [1:0] len,
                                 input logic [19:0] pid, input logic [15:0] tid,
                                 input logic [63:0] majId);
        bus.bundleValid_i      = valid;
        bus.bundle_i           = makeBundle(base);
        bus.bundleAddress_i    = addr;
        bus.bundleLen_i        = len;
        bus.bundlePid_i        = pid;
        bus.bundleTid_i        = tid;
        bus.bundleStartMajId_i = majId;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkHead(input string tag, input logic [31:0] inst, input logic [63:0] addr,
                             input logic [63:0] majId, input logic [19:0] pid, input logic [15:0] tid);
        checkOutput({tag, ".valid"}, 64'(bus.instValid_o), 64'd1);
        checkOutput({tag, ".inst"},  64'(bus.inst_o), 64'(inst));
        checkOutput({tag, ".addr"},  bus.instAddress_o, addr);
        checkOutput({tag, ".majId"}, bus.instMajId_o, majId);
        checkOutput({tag, ".pid"},   64'(bus.instPid_o), 64'(pid));
        checkOutput({tag, ".tid"},   64'(bus.instTid_o), 64'(tid));
    endtask

    task automatic checkEmpty(input string tag);
        checkOutput({tag, ".valid"}, 64'(bus.instValid_o), 64'd0);
        checkOutput({tag, ".inst"},  64'(bus.inst_o), 64'd0);
        checkOutput({tag, ".addr"},  bus.instAddress_o, 64'd0);
        checkOutput({tag, ".majId"}, bus.instMajId_o, 64'd0);
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        reset_i     = 1'b0;
        bus.flush_i       = 1'b0;
        bus.decodeReady_i = 1'b0;
        applyStimulus(1'b0, 32'h0, 64'h0, 2'd0, 20'h0, 16'h0, 64'h0);

        // Reset state
        #3;
        checkEmpty("reset");
        checkOutput("reset.stall", 64'(bus.fetchStall_o), 64'd0);
        checkOutput("reset.ovf",   64'(bus.overflow_o), 64'd0);
        tick();
        tick();
        reset_i = 1'b1;

        // One 4-instruction bundle drained back to back
        bus.decodeReady_i = 1'b1;
        applyStimulus(1'b1, 32'hA000_0000, 64'h1000, 2'd3, 20'h5, 16'h7, 64'd10);
        tick();
        bus.bundleValid_i = 1'b0;
        checkHead("t1.s0", 32'hA000_0000, 64'h1000, 64'd10, 20'h5, 16'h7);
        tick();
        checkHead("t1.s1", 32'hA000_0001, 64'h1004, 64'd11, 20'h5, 16'h7);
        tick();
        checkHead("t1.s2", 32'hA000_0002, 64'h1008, 64'd12, 20'h5, 16'h7);
        tick();
        checkHead("t1.s3", 32'hA000_0003, 64'h100C, 64'd13, 20'h5, 16'h7);
        tick();
        checkEmpty("t1.done");

        // Fill with decode stalled: stall at 3, accept 4th, drop 5th
        bus.decodeReady_i = 1'b0;
        applyStimulus(1'b1, 32'hB100_0000, 64'h2000, 2'd1, 20'h11, 16'h21, 64'd100);
        tick();
        applyStimulus(1'b1, 32'hB200_0000, 64'h2100, 2'd1, 20'h12, 16'h22, 64'd110);
        tick();
        checkOutput("t2.stall2", 64'(bus.fetchStall_o), 64'd0);
        applyStimulus(1'b1, 32'hB300_0000, 64'h2200, 2'd1, 20'h13, 16'h23, 64'd120);
        tick();
        checkOutput("t2.stall3", 64'(bus.fetchStall_o), 64'd1);
        applyStimulus(1'b1, 32'hB400_0000, 64'h2300, 2'd1, 20'h14, 16'h24, 64'd130);
        tick();
        checkOutput("t2.ovf4", 64'(bus.overflow_o), 64'd0);
        applyStimulus(1'b1, 32'hB500_0000, 64'h2400, 2'd1, 20'h15, 16'h25, 64'd140);
        tick();
        bus.bundleValid_i = 1'b0;
        checkOutput("t2.ovf5",   64'(bus.overflow_o), 64'd1);
        checkOutput("t2.stall5", 64'(bus.fetchStall_o), 64'd1);
        checkHead("t2.head", 32'hB100_0000, 64'h2000, 64'd100, 20'h11, 16'h21);
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        checkOutput("t2.flushValid", 64'(bus.instValid_o), 64'd0);
        checkOutput("t2.flushOvf",   64'(bus.overflow_o), 64'd0);
        checkOutput("t2.flushStall", 64'(bus.fetchStall_o), 64'd0);

        // Full queue: push and final-slot pop in the same cycle
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'hC000_0000 + 32'(i) * 32'h0100_0000, 64'h3000 + 64'(i) * 64'h10,
                          2'd0, 20'h30, 16'h40, 64'd200 + 64'(i));
            tick();
        end
        checkOutput("t4.stall", 64'(bus.fetchStall_o), 64'd1);
        checkHead("t4.headC0", 32'hC000_0000, 64'h3000, 64'd200, 20'h30, 16'h40);
        bus.decodeReady_i = 1'b1;
        applyStimulus(1'b1, 32'hC400_0000, 64'h3040, 2'd0, 20'h30, 16'h40, 64'd204);
        tick();
        checkOutput("t4.ovfSwap", 64'(bus.overflow_o), 64'd0);
        checkHead("t4.headC1", 32'hC100_0000, 64'h3010, 64'd201, 20'h30, 16'h40);
        bus.decodeReady_i = 1'b0;
        applyStimulus(1'b1, 32'hC500_0000, 64'h3050, 2'd0, 20'h30, 16'h40, 64'd205);
        tick();
        bus.bundleValid_i = 1'b0;
        checkOutput("t4.ovfStillFull", 64'(bus.overflow_o), 64'd1);
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;

        // Flush mid-bundle with a bundle on the input
        applyStimulus(1'b1, 32'hD100_0000, 64'h4000, 2'd3, 20'h50, 16'h60, 64'd300);
        tick();
        applyStimulus(1'b1, 32'hD200_0000, 64'h4100, 2'd3, 20'h51, 16'h61, 64'd310);
        tick();
        bus.bundleValid_i = 1'b0;
        bus.decodeReady_i = 1'b1;
        tick();
        tick();
        checkHead("t5.s2", 32'hD100_0002, 64'h4008, 64'd302, 20'h50, 16'h60);
        bus.flush_i = 1'b1;
        applyStimulus(1'b1, 32'hE000_0000, 64'h4800, 2'd1, 20'h52, 16'h62, 64'd320);
        tick();
        bus.flush_i = 1'b0;
        bus.bundleValid_i = 1'b0;
        checkEmpty("t5.flushed");
        checkOutput("t5.stall", 64'(bus.fetchStall_o), 64'd0);
        tick();
        checkOutput("t5.noEmit1", 64'(bus.instValid_o), 64'd0);
        tick();
        checkOutput("t5.noEmit2", 64'(bus.instValid_o), 64'd0);

        // len=0 then len=1 with no bubble between bundles
        applyStimulus(1'b1, 32'hF100_0000, 64'h5000, 2'd0, 20'h70, 16'h80, 64'd400);
        tick();
        checkHead("t3.f1", 32'hF100_0000, 64'h5000, 64'd400, 20'h70, 16'h80);
        applyStimulus(1'b1, 32'hF200_0000, 64'h6000, 2'd1, 20'h71, 16'h81, 64'd500);
        tick();
        bus.bundleValid_i = 1'b0;
        checkHead("t3.f2s0", 32'hF200_0000, 64'h6000, 64'd500, 20'h71, 16'h81);
        tick();
        checkHead("t3.f2s1", 32'hF200_0001, 64'h6004, 64'd501, 20'h71, 16'h81);
        tick();
        checkEmpty("t3.done");

        // Hold at s=1, then address and major ID wrap at s=2
        applyStimulus(1'b1, 32'h9000_0000, 64'hFFFF_FFFF_FFFF_FFF8, 2'd3, 20'h90, 16'hA0,
                      64'hFFFF_FFFF_FFFF_FFFE);
        tick();
        bus.bundleValid_i = 1'b0;
        checkHead("t6.s0", 32'h9000_0000, 64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFE, 20'h90, 16'hA0);
        tick();
        bus.decodeReady_i = 1'b0;
        checkHead("t6.s1", 32'h9000_0001, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFF, 20'h90, 16'hA0);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkHead("t6.hold", 32'h9000_0001, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFF, 20'h90, 16'hA0);
        end
        bus.decodeReady_i = 1'b1;
        tick();
        bus.decodeReady_i = 1'b0;
        checkHead("t6.s2wrap", 32'h9000_0002, 64'h0, 64'h0, 20'h90, 16'hA0);

        // Asynchronous reset mid-bundle
        #2;
        reset_i = 1'b0;
        #1;
        checkEmpty("asyncReset");
        tick();
        reset_i = 1'b1;
        tick();
        checkOutput("postReset.valid", 64'(bus.instValid_o), 64'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
